// File: rtl/alu_muldiv_if.sv
// Execute-stage bus for alu_muldiv: instruction operands, forwarding inputs
// and the results/status returned to the pipeline.
interface alu_muldiv_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic [4:0]       alu_control;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] imm;
  logic             alu_source;
  logic             alu_source_shift;
  logic [1:0]       fw_alu1;
  logic [1:0]       fw_alu2;
  logic [WIDTH-1:0] alu_outM;
  logic [WIDTH-1:0] write_resultW;
  logic [WIDTH-1:0] alu_out;
  logic             zero;
  logic [WIDTH-1:0] write_data;
  logic             stall;
  logic             md_busy;
  logic             md_done;
  logic             ovf;

  // Pipeline side: drives the instruction, receives results.
  modport master (
    output in_valid, alu_control, rs, rt, shamt, imm, alu_source,
           alu_source_shift, fw_alu1, fw_alu2, alu_outM, write_resultW,
    input  alu_out, zero, write_data, stall, md_busy, md_done, ovf
  );

  // Execute unit side.
  modport slave (
    input  in_valid, alu_control, rs, rt, shamt, imm, alu_source,
           alu_source_shift, fw_alu1, fw_alu2, alu_outM, write_resultW,
    output alu_out, zero, write_data, stall, md_busy, md_done, ovf
  );
endinterface

// File: rtl/alu_muldiv.sv
// Execute-stage unit: single-cycle ALU with forwarding muxes plus an
// iterative multiply/divide engine owning the HI/LO registers.
// Optional macro ALU_OVF_EN enables the signed add/sub overflow flag.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         rst_n,
  alu_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_ADD   = 5'h01;
  localparam logic [4:0] OP_SUB   = 5'h02;
  localparam logic [4:0] OP_AND   = 5'h03;
  localparam logic [4:0] OP_OR    = 5'h04;
  localparam logic [4:0] OP_XOR   = 5'h05;
  localparam logic [4:0] OP_NOR   = 5'h06;
  localparam logic [4:0] OP_SLT   = 5'h07;
  localparam logic [4:0] OP_SLL   = 5'h08;
  localparam logic [4:0] OP_SRL   = 5'h09;
  localparam logic [4:0] OP_SRA   = 5'h0A;
  localparam logic [4:0] OP_SLTU  = 5'h0B;
  localparam logic [4:0] OP_MULT  = 5'h0C;
  localparam logic [4:0] OP_MULTU = 5'h0D;
  localparam logic [4:0] OP_DIV   = 5'h0E;
  localparam logic [4:0] OP_DIVU  = 5'h0F;
  localparam logic [4:0] OP_MFHI  = 5'h10;
  localparam logic [4:0] OP_MFLO  = 5'h11;
  localparam logic [4:0] OP_MTHI  = 5'h12;
  localparam logic [4:0] OP_MTLO  = 5'h13;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;      // mul: {acc, multiplier}; div: {rem, quotient}
  logic [WIDTH-1:0]   b_q, b_d;      // multiplicand / divisor magnitude
  logic               neg_q, neg_d;  // negate product / quotient
  logic               rneg_q, rneg_d; // remainder takes dividend sign
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0] fw_a, fw_b, op_a, op_b;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic [SHW-1:0]   sh;
  logic             busy, is_md_op, accept;

  // Operand selection: shift/immediate override forwarding, forwarding overrides the register file.
  always_comb begin
    fw_a = (bus.fw_alu1 == 2'b10) ? bus.alu_outM :
           (bus.fw_alu1 == 2'b01) ? bus.write_resultW : bus.rs;
    fw_b = (bus.fw_alu2 == 2'b10) ? bus.alu_outM :
           (bus.fw_alu2 == 2'b01) ? bus.write_resultW : bus.rt;
    op_a = bus.alu_source_shift ? {{(WIDTH-SHW){1'b0}}, bus.shamt} : fw_a;
    op_b = bus.alu_source ? bus.imm : fw_b;
    sh   = op_a[SHW-1:0];
    sum  = op_a + op_b;
    diff = op_a - op_b;
  end

  // Single-cycle ALU result; engine-issue and HI/LO writes return 0.
  always_comb begin
    alu_res = '0;
    case (bus.alu_control)
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLL:  alu_res = op_b << sh;
      OP_SRL:  alu_res = op_b >> sh;
      OP_SRA:  alu_res = $signed(op_b) >>> sh;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign is_md_op   = (bus.alu_control >= OP_MULT) && (bus.alu_control <= OP_MTLO);
  assign accept     = bus.in_valid & ~bus.stall;

  assign bus.alu_out    = alu_res;
  assign bus.zero       = (alu_res == '0);
  assign bus.write_data = fw_b;
  assign bus.stall      = bus.in_valid & busy & is_md_op;
  assign bus.md_busy    = busy;
  assign bus.md_done    = (state_q == S_FIX);

`ifdef ALU_OVF_EN
  logic ovf_add, ovf_sub;
  // Two's-complement overflow: operand signs vs result sign.
  always_comb begin
    ovf_add = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1]  != op_a[WIDTH-1]);
    ovf_sub = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
  end
  assign bus.ovf = bus.in_valid &
                   (((bus.alu_control == OP_ADD) & ovf_add) |
                    ((bus.alu_control == OP_SUB) & ovf_sub));
`else
  assign bus.ovf = 1'b0;
`endif

  logic             sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] prod_fixed;

  // Engine sequencing: issue, one bit per cycle, then sign fix and HI/LO write.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    b_d      = b_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    sgn_op = (bus.alu_control == OP_MULT) || (bus.alu_control == OP_DIV);
    a_neg  = sgn_op & op_a[WIDTH-1];
    b_neg  = sgn_op & op_b[WIDTH-1];
    mag_a  = a_neg ? -op_a : op_a;
    mag_b  = b_neg ? -op_b : op_b;

    mul_sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
    div_shift  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    div_trial  = div_shift - {1'b0, b_q};
    prod_fixed = neg_q ? -p_q : p_q;

    case (state_q)
      S_IDLE: begin
        if (accept && (bus.alu_control >= OP_MULT) && (bus.alu_control <= OP_DIVU)) begin
          // Both engines start from the same load: low half = |A|, upper half cleared.
          p_d      = {{WIDTH{1'b0}}, mag_a};
          b_d      = mag_b;
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          is_div_d = (bus.alu_control == OP_DIV) || (bus.alu_control == OP_DIVU);
          cnt_d    = CW'(WIDTH);
          state_d  = is_div_d ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        p_d   = {mul_sum, p_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_DIV: begin
        if (!div_trial[WIDTH])
          p_d = {div_trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        else
          p_d = {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      default: begin // S_FIX
        if (is_div_q) begin
          // With a zero divisor the remainder ends as |A|, so re-applying the
          // dividend sign reproduces the raw dividend for HI.
          hi_d = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
          if (b_q == '0) lo_d = '1;
          else           lo_d = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        end else begin
          {hi_d, lo_d} = prod_fixed;
        end
        state_d = S_IDLE;
      end
    endcase

    // mthi/mtlo stall while busy, so they never collide with the FIX write.
    if (accept && (bus.alu_control == OP_MTHI)) hi_d = op_a;
    if (accept && (bus.alu_control == OP_MTLO)) lo_d = op_a;
  end

  // Engine and HI/LO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end
endmodule
